// File: rtl/div_sched_pkg.sv
// Shared types and defaults for the divider scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_sched_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit at or above ptr, searching upward with wrap.
// Latency: combinational.
// Backpressure: none; the caller decides whether the pick is taken.
// Ports: req (request vector), ptr (search start), gnt_oh/gnt_id (winner), gnt_any (any request set).
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_any
);

    always_comb begin : pick
        int idx;
        idx     = 0;
        gnt_oh  = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!gnt_any && req[idx]) begin
                gnt_oh[idx] = 1'b1;
                gnt_id      = ID_W'(idx);
                gnt_any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// Shares one sequential divider among N_REQ requesters with round-robin arbitration.
// Latency: gnt to resp_valid = divider busy cycles + 4 (2 cycles for a zero-divisor bypass).
// Backpressure: one job in flight; new grants only in IDLE while div_ready is high.
// Ports: clk/reset (sync, active low); req + packed operands from clients; gnt/busy/resp_* to
// clients; div_start/div_dividend/div_divisor/div_ready/div_quot/div_rem to the divider.
// Optional: DIV_ZERO_BYPASS_EN answers divisor==0 locally and adds the resp_dz output.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] dividend_in,
    input  logic [N_REQ*WIDTH-1:0] divisor_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   resp_valid,
    output logic [ID_W-1:0]        resp_id,
    output logic [WIDTH-1:0]       resp_quot,
    output logic [WIDTH-1:0]       resp_rem,
    output logic                   div_start,
    output logic [WIDTH-1:0]       div_dividend,
    output logic [WIDTH-1:0]       div_divisor,
    input  logic                   div_ready,
    input  logic [WIDTH-1:0]       div_quot,
    input  logic [WIDTH-1:0]       div_rem
`ifdef DIV_ZERO_BYPASS_EN
    ,
    output logic                   resp_dz
`endif
);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic                 div_start_q, div_start_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [ID_W-1:0]      id_q, id_d;
    // Result is parked here in RESP and only copied to the outputs as resp_valid
    // rises, so the client-visible result changes exactly with the strobe.
    logic [WIDTH-1:0]     res_quot_q, res_quot_d;
    logic [WIDTH-1:0]     res_rem_q, res_rem_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]      resp_id_q, resp_id_d;
    logic [WIDTH-1:0]     resp_quot_q, resp_quot_d;
    logic [WIDTH-1:0]     resp_rem_q, resp_rem_d;
`ifdef DIV_ZERO_BYPASS_EN
    logic                 res_dz_q, res_dz_d;
    logic                 resp_dz_q, resp_dz_d;
`endif

    logic [N_REQ-1:0]     arb_oh;
    logic [ID_W-1:0]      arb_id;
    logic                 arb_any;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_id  (arb_id),
        .gnt_any (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = '0;
        div_start_d  = 1'b0;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        id_d         = id_q;
        res_quot_d   = res_quot_q;
        res_rem_d    = res_rem_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_quot_d  = resp_quot_q;
        resp_rem_d   = resp_rem_q;
`ifdef DIV_ZERO_BYPASS_EN
        res_dz_d     = res_dz_q;
        resp_dz_d    = resp_dz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_any && div_ready) begin
                    gnt_d   = arb_oh;
                    dvd_d   = dividend_in[arb_id*WIDTH +: WIDTH];
                    dvs_d   = divisor_in[arb_id*WIDTH +: WIDTH];
                    id_d    = arb_id;
                    ptr_d   = (arb_id == ID_W'(N_REQ - 1)) ? '0 : arb_id + ID_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef DIV_ZERO_BYPASS_EN
                if (dvs_q == '0) begin
                    res_quot_d = '1;
                    res_rem_d  = dvd_q;
                    res_dz_d   = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    div_start_d = 1'b1;
                    state_d     = ST_LAUNCH;
                end
`else
                div_start_d = 1'b1;
                state_d     = ST_LAUNCH;
`endif
            end
            // Ready still reads high the cycle start is sampled; wait for the drop
            // so a stale ready is not mistaken for completion.
            ST_LAUNCH: begin
                if (!div_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_ready) begin
                    res_quot_d = div_quot;
                    res_rem_d  = div_rem;
`ifdef DIV_ZERO_BYPASS_EN
                    res_dz_d   = 1'b0;
`endif
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid_d = 1'b1;
                resp_id_d    = id_q;
                resp_quot_d  = res_quot_q;
                resp_rem_d   = res_rem_q;
`ifdef DIV_ZERO_BYPASS_EN
                resp_dz_d    = res_dz_q;
`endif
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            div_start_q  <= 1'b0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            id_q         <= '0;
            res_quot_q   <= '0;
            res_rem_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_quot_q  <= '0;
            resp_rem_q   <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            res_dz_q     <= 1'b0;
            resp_dz_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            div_start_q  <= div_start_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            id_q         <= id_d;
            res_quot_q   <= res_quot_d;
            res_rem_q    <= res_rem_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_quot_q  <= resp_quot_d;
            resp_rem_q   <= resp_rem_d;
`ifdef DIV_ZERO_BYPASS_EN
            res_dz_q     <= res_dz_d;
            resp_dz_q    <= resp_dz_d;
`endif
        end
    end

    assign gnt          = gnt_q;
    assign busy         = (state_q != ST_IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_quot    = resp_quot_q;
    assign resp_rem     = resp_rem_q;
    assign div_start    = div_start_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
`ifdef DIV_ZERO_BYPASS_EN
    assign resp_dz      = resp_dz_q;
`endif

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural divider and a result scoreboard.
// Latency: divider busy for op_len cycles after sampling start.
// Backpressure: test-controlled hold_low masks the divider ready.
module tb_div_sched;

    localparam int N = 4;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] dividend_in;
    logic [N*W-1:0] divisor_in;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           resp_valid;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_quot;
    logic [W-1:0]   resp_rem;
    logic           div_start;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic           div_ready;
    logic [W-1:0]   div_quot;
    logic [W-1:0]   div_rem;
`ifdef DIV_ZERO_BYPASS_EN
    logic           resp_dz;
`endif

    always #5 clk = ~clk;

    div_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .dividend_in  (dividend_in),
        .divisor_in   (divisor_in),
        .gnt          (gnt),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_quot    (resp_quot),
        .resp_rem     (resp_rem),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_ready    (div_ready),
        .div_quot     (div_quot),
        .div_rem      (div_rem)
`ifdef DIV_ZERO_BYPASS_EN
        ,
        .resp_dz      (resp_dz)
`endif
    );

    // Behavioural divider: ready drops the cycle after start, stays low op_len cycles.
    int         op_len;
    logic       hold_low;
    logic       m_ready;
    int         m_cnt;
    logic [W-1:0] m_q, m_r;

    always @(posedge clk) begin
        if (!reset) begin
            m_ready <= 1'b1;
            m_cnt   <= 0;
            m_q     <= '0;
            m_r     <= '0;
        end else if (m_ready) begin
            if (div_start) begin
                m_ready <= 1'b0;
                m_cnt   <= op_len;
                if (div_divisor == '0) begin
                    m_q <= '1;
                    m_r <= div_dividend;
                end else begin
                    m_q <= div_dividend / div_divisor;
                    m_r <= div_dividend % div_divisor;
                end
            end
        end else if (m_cnt <= 1) begin
            m_ready <= 1'b1;
        end else begin
            m_cnt <= m_cnt - 1;
        end
    end

    assign div_ready = m_ready & ~hold_low;
    assign div_quot  = m_ready ? m_q : 64'hDEAD_BEEF_DEAD_BEEF;
    assign div_rem   = m_ready ? m_r : 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct {
        int           id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           gcyc;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           exp_gnt[$];
    logic [W-1:0] op_a[N];
    logic [W-1:0] op_b[N];
    logic         sticky;
    int           cyc, gnt_cyc, gnt_seen, resp_seen, starts;
    int           n_assert, n_fail;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        op_a[i] = a;
        op_b[i] = b;
        dividend_in[i*W +: W] = a;
        divisor_in[i*W +: W]  = b;
    endtask

    // One clock: sample just after the edge, score grants/responses/starts.
    task automatic tick();
        exp_t e;
        int   id;
        @(posedge clk);
        #1;
        cyc++;
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", W'(sb.size()), W'(1));
            end else begin
                e = sb.pop_front();
                check("resp_id", W'(resp_id), W'(e.id));
                check("resp_quot", resp_quot, e.q);
                check("resp_rem", resp_rem, e.r);
                check("resp_latency", W'(cyc - e.gcyc), W'(e.lat));
`ifdef DIV_ZERO_BYPASS_EN
                check("resp_dz", W'(resp_dz), W'(e.dz));
`endif
            end
            resp_seen++;
        end
        if (gnt !== '0) begin
            id = -1;
            for (int k = 0; k < N; k++) if (gnt[k] === 1'b1) id = k;
            check("gnt_onehot", W'($onehot(gnt)), W'(1));
            if (exp_gnt.size() != 0) check("gnt_order", W'(id), W'(exp_gnt.pop_front()));
            else check("gnt_unexpected", W'(exp_gnt.size()), W'(1));
            check("job_overlap", W'(sb.size()), W'(0));
            if (id >= 0) begin
                e.id   = id;
                e.gcyc = cyc;
`ifdef DIV_ZERO_BYPASS_EN
                if (op_b[id] == '0) begin
                    e.q = '1; e.r = op_a[id]; e.dz = 1'b1; e.lat = 2;
                end else begin
                    e.q = op_a[id] / op_b[id]; e.r = op_a[id] % op_b[id]; e.dz = 1'b0; e.lat = op_len + 4;
                end
`else
                e.q = op_a[id] / op_b[id]; e.r = op_a[id] % op_b[id]; e.dz = 1'b0; e.lat = op_len + 4;
`endif
                sb.push_back(e);
                if (!sticky) req[id] = 1'b0;
            end
            gnt_cyc = cyc;
            gnt_seen++;
        end
        if (div_start === 1'b1) begin
            check("start_timing", W'(cyc), W'(gnt_cyc + 1));
            starts++;
        end
    endtask

    task automatic wait_gnt(input int target, input int bound);
        int n = 0;
        while (gnt_seen < target && n < bound) begin tick(); n++; end
        if (gnt_seen < target) check("gnt_timeout", W'(gnt_seen), W'(target));
    endtask

    task automatic wait_resp(input int target, input int bound);
        int n = 0;
        while (resp_seen < target && n < bound) begin tick(); n++; end
        if (resp_seen < target) check("resp_timeout", W'(resp_seen), W'(target));
    endtask

    int starts0;

    initial begin
        reset = 1'b0; req = '0; hold_low = 1'b0; op_len = 6; sticky = 1'b0;
        dividend_in = '0; divisor_in = '0;
        cyc = 0; gnt_cyc = -10; gnt_seen = 0; resp_seen = 0; starts = 0;
        n_assert = 0; n_fail = 0;
        set_op(0, 64'd1000, 64'd3);
        set_op(1, 64'd77777, 64'd10);
        set_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd13);
        set_op(3, 64'd5, 64'd9);

        // Reset held with all requests pending.
        req = 4'b1111; sticky = 1'b1;
        repeat (3) begin
            tick();
            check("rst_gnt", W'(gnt), W'(0));
            check("rst_busy", W'(busy), W'(0));
            check("rst_resp_valid", W'(resp_valid), W'(0));
            check("rst_div_start", W'(div_start), W'(0));
            check("rst_resp_id", W'(resp_id), W'(0));
            check("rst_resp_quot", resp_quot, W'(0));
            check("rst_resp_rem", resp_rem, W'(0));
            check("rst_div_dividend", div_dividend, W'(0));
            check("rst_div_divisor", div_divisor, W'(0));
        end
        reset = 1'b1;
        foreach (exp_gnt[i]) exp_gnt.delete(i);
        exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
        exp_gnt.push_back(3); exp_gnt.push_back(0);
        tick();
        check("first_gnt", W'(gnt), W'(4'b0001));
        check("busy_after_gnt", W'(busy), W'(1));
        // Continuous requests: strict round robin 0,1,2,3,0.
        wait_resp(5, 400);
        req = '0; sticky = 1'b0;
        repeat (3) tick();

        // Single requester, long divider job, operand change after grant.
        op_len = 66;
        set_op(2, 64'd100, 64'd7);
        exp_gnt.push_back(2);
        req[2] = 1'b1;
        wait_gnt(6, 20);
        set_op(2, 64'd999, 64'd1);
        wait_resp(6, 200);
        check("single_quot", resp_quot, W'(14));
        check("single_rem", resp_rem, W'(2));
        check("single_id", W'(resp_id), W'(2));
        repeat (2) tick();

        // Divider not ready: grant withheld until ready returns.
        op_len = 6;
        hold_low = 1'b1;
        set_op(1, 64'd50, 64'd6);
        exp_gnt.push_back(1);
        req[1] = 1'b1;
        repeat (4) begin
            tick();
            check("no_gnt_not_ready", W'(gnt), W'(0));
        end
        hold_low = 1'b0;
        tick();
        check("gnt_after_ready", W'(gnt), W'(4'b0010));
        wait_resp(7, 50);
        repeat (2) tick();

        // Reset while the divider is busy: job abandoned, no response.
        op_len = 20;
        set_op(3, 64'd12345, 64'd100);
        exp_gnt.push_back(3);
        req[3] = 1'b1;
        wait_gnt(8, 20);
        repeat (5) tick();
        reset = 1'b0;
        tick();
        sb.delete();
        reset = 1'b1;
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_resp_valid", W'(resp_valid), W'(0));
        check("midrst_resp_quot", resp_quot, W'(0));
        check("midrst_div_start", W'(div_start), W'(0));
        repeat (40) tick();
        check("midrst_no_resp", W'(resp_seen), W'(7));
        set_op(3, 64'd54321, 64'd123);
        exp_gnt.push_back(3);
        req[3] = 1'b1;
        wait_gnt(9, 20);
        wait_resp(8, 60);

`ifdef DIV_ZERO_BYPASS_EN
        // Zero divisor answered locally, divider never started.
        op_len = 6;
        repeat (2) tick();
        starts0 = starts;
        set_op(0, 64'h1234, 64'd0);
        exp_gnt.push_back(0);
        req[0] = 1'b1;
        wait_gnt(10, 20);
        wait_resp(9, 20);
        check("dz_quot", resp_quot, 64'hFFFF_FFFF_FFFF_FFFF);
        check("dz_rem", resp_rem, 64'h1234);
        check("dz_flag", W'(resp_dz), W'(1));
        check("dz_no_start", W'(starts), W'(starts0));
`else
        starts0 = starts;
`endif
        repeat (3) tick();
        check("leftover_sb", W'(sb.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Round-robin scheduler that shares one 64-bit sequential divider among N_REQ requesters.
- Arbitrates requests, captures the winner's operands, pulses the divider start, and tracks the divider's ready handshake.
- Returns quotient/remainder tagged with the requester index.
- Sits between client blocks and the single divider instance (start/ready/data_in-style control).

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 64, operand/result width
- ID_W, $clog2(N_REQ), requester tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- req  in  N_REQ  per-requester request, held until granted
- dividend_in  in  N_REQ*WIDTH  packed dividends, slot i at [i*WIDTH +: WIDTH]
- divisor_in  in  N_REQ*WIDTH  packed divisors, same packing
- gnt  out  N_REQ  one-hot, one-cycle pulse; operands captured in that cycle
- busy  out  1  high whenever FSM is not IDLE
- resp_valid  out  1  one-cycle result strobe
- resp_id  out  ID_W  requester index of the result
- resp_quot  out  WIDTH  quotient
- resp_rem  out  WIDTH  remainder
- div_start  out  1  start pulse to the divider
- div_dividend  out  WIDTH  registered operand to the divider
- div_divisor  out  WIDTH  registered operand to the divider
- div_ready  in  1  divider idle/done indication
- div_quot  in  WIDTH  divider quotient
- div_rem  in  WIDTH  divider remainder

Behaviour:
- Reset (reset==0 at posedge):
  - FSM returns to IDLE; RR pointer = 0.
  - gnt, div_start, resp_valid, busy = 0.
  - resp_id, resp_quot, resp_rem, div_dividend, div_divisor = 0.
  - Reset mid-operation abandons the in-flight job; no response is issued.
- FSM states: IDLE, ISSUE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req bit is set and div_ready==1, grant the first set bit at or after the pointer, searching upward with wrap.
  - Pulse gnt[i] for one cycle. Register operands into div_dividend/div_divisor, and register id.
  - Pointer <= (i+1) mod N_REQ. Next state ISSUE.
  - If div_ready==0, no grant is issued.
- ISSUE: div_start=1 for exactly one cycle -> LAUNCH.
- LAUNCH:
  - Wait for div_ready==0 (divider accepted), then -> WAIT.
  - The divider drops ready the cycle after start.
- WAIT: wait for div_ready==1, then capture div_quot/div_rem -> RESP.
- RESP: resp_valid=1 for one cycle, with resp_id/quot/rem valid -> IDLE.
- Result outputs hold their values until the next RESP.
- Latency:
  - gnt to resp_valid = divider op length + 4 cycles.
  - With a 66-cycle divider job (load + 64 ops + ready), resp_valid fires 69-70 cycles after gnt.
- Req rules:
  - A req dropped before grant is ignored.
  - A req held after gnt is treated as a new request: re-arbitrated next IDLE, after other waiting requesters by RR order.
  - Simultaneous requests: strict RR, no starvation. Worst-case wait is N_REQ-1 jobs.
- Operands are registered in the grant cycle; requester input changes afterwards do not affect the job.
- At most one job in flight; no queueing.

Optional Feature:
- Macro DIV_ZERO_BYPASS_EN.
- Defined:
  - A granted job with divisor==0 skips ISSUE/LAUNCH/WAIT; the next cycle is RESP.
  - In RESP: resp_quot = all ones, resp_rem = dividend, plus an extra output port resp_dz = 1.
  - resp_dz = 0 for normal results; it is cleared on reset.
- Undefined:
  - Zero divisors are sent to the divider unchanged.
  - The resp_dz port does not exist.

Decomposition:
- Package div_sched_pkg holds:
  - state enum (IDLE=0, ISSUE=1, LAUNCH=2, WAIT=3, RESP=4; 3-bit)
  - default N_REQ and WIDTH constants
- Sub-module rr_arbiter (N_REQ): combinational pick of the one-hot winner from req and pointer.
- Pointer register stays in div_sched.

Test Plan:
- Reset with req=4'b1111 held low-reset for 3 cycles -> no gnt, all outputs 0; after release, gnt=4'b0001 first.
- Single req[2], dividend=100, divisor=7 -> gnt[2] one pulse, div_start one cycle later; resp_valid with resp_id=2, quot=14, rem=2.
- req=4'b1111 continuously with distinct operands -> grant order 0,1,2,3,0, each result tagged correctly; never two jobs overlapping.
- div_ready forced low in IDLE with req[1] set -> no gnt until div_ready=1, then gnt[1] the following edge.
- Reset asserted during WAIT -> next cycle busy=0, resp_valid never fires; new req[3] afterwards is served normally.
- DIV_ZERO_BYPASS_EN, req[0] with dividend=0x1234, divisor=0 -> resp_valid two cycles after gnt, quot=0xFFFF_FFFF_FFFF_FFFF, rem=0x1234, resp_dz=1, div_start never asserted.
